sysid_probe: RTL and testbench
==============================

SYSID_PROBE -- requirements
Module: sysid_probe

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd1541173828, system ID value required at word address 0.
REQ-002 Parameter EXPECTED_TS, default 32'd1316451569, build timestamp required at word address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 16'd255, maximum cycles spent in any bus state before abort.
REQ-004 clk  input  1  sole clock, all logic rising-edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to run one check sequence.
REQ-007 avm_address  output  1  word address to the system-ID slave (0 = ID, 1 = timestamp).
REQ-008 avm_read  output  1  Avalon-MM read strobe.
REQ-009 avm_waitrequest  input  1  slave stall; read not accepted while high.
REQ-010 avm_readdata  input  32  read data, qualified by avm_readdatavalid.
REQ-011 avm_readdatavalid  input  1  read data valid strobe.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse at end of sequence.
REQ-014 pass  output  1  both words matched, no timeout; valid from done until next accepted start.
REQ-015 id_err / ts_err / timeout  output  1 each  sticky per-run error flags.
REQ-016 id_value / ts_value  output  32 each  captured read data.

Function
REQ-017 FSM states: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, FIN.
REQ-018 IDLE: start=1 -> clear pass, id_err, ts_err, timeout, id_value, ts_value; go to RD_ID next cycle; busy=1 from that cycle.
REQ-019 start while not in IDLE is ignored, no queuing.
REQ-020 RD_ID/RD_TS: avm_read=1, avm_address=0/1 held stable; read accepted in cycle where avm_waitrequest=0; then go to WT_ID/WT_TS.
REQ-021 avm_read=0 and avm_address=0 in all other states.
REQ-022 WT_ID: avm_readdatavalid=1 -> capture avm_readdata into id_value, set id_err if value != EXPECTED_ID, go to RD_TS; same for WT_TS/ts_value/EXPECTED_TS/ts_err, go to FIN.
REQ-023 Earliest readdatavalid accepted is the cycle after read acceptance; readdatavalid in any non-WT state is ignored.
REQ-024 A mismatch on the ID word does not abort; timestamp read still executes.
REQ-025 16-bit timeout counter cleared on every state change; increments each cycle in RD_*/WT_*; counter reaching TIMEOUT_CYCLES sets timeout=1, drops avm_read same cycle-boundary, goes to FIN.
REQ-026 FIN (one cycle): done=1, busy=0 next cycle, pass = !id_err & !ts_err & !timeout; return to IDLE.
REQ-027 Minimum sequence with zero wait states and latency 1: start at cycle 0, done at cycle 6.
REQ-028 Result outputs hold until next accepted start.

Reset
REQ-029 reset_n low at any time (including mid-transfer) -> IDLE immediately; avm_read=0, avm_address=0, busy=0, done=0, pass=0, all error flags 0, id_value=ts_value=0, counter=0.
REQ-030 A readdatavalid arriving after reset release for a pre-reset read is ignored (IDLE).

Structure
REQ-031 State encoding enum and default EXPECTED_ID/EXPECTED_TS/TIMEOUT_CYCLES constants live in a shared package sysid_pkg.
REQ-032 Single flat module; no sub-modules.

Verification
REQ-033 Slave returns 1541173828 / 1316451569, no waitrequest, latency 1 -> done at cycle 6, pass=1, all errors 0.
REQ-034 Slave returns 0x0 at address 0, correct TS -> id_err=1, ts_err=0, pass=0, id_value=0, both reads issued.
REQ-035 waitrequest high 3 cycles on each read, latency 2 -> avm_address/avm_read stable while stalled, pass=1, done at cycle 14.
REQ-036 readdatavalid never asserted, TIMEOUT_CYCLES=8 -> timeout=1 after 8 cycles in WT_ID, pass=0, ts read not issued.
REQ-037 reset_n pulsed low during WT_TS, then stray readdatavalid -> outputs at reset values, FSM stays IDLE; subsequent start completes with pass=1.
REQ-038 start pulsed during busy -> ignored, exactly one done pulse.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared state encoding and default constants for the system-ID probe.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WT_ID,
    RD_TS,
    WT_TS,
    FIN
  } state_t;

  localparam logic [31:0] DEFAULT_ID      = 32'd1541173828;
  localparam logic [31:0] DEFAULT_TS      = 32'd1316451569;
  localparam logic [15:0] DEFAULT_TIMEOUT = 16'd255;

endpackage

// File: rtl/sysid_probe.sv
// Reads the system-ID and build-timestamp words over Avalon-MM and reports
// whether both match the values this image was built against.
module sysid_probe
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_TS,
  parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_err,
  output logic        ts_err,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic        in_bus;
  logic        cap_id;
  logic        cap_ts;
  logic        expire;

  always_comb begin
    state_nx    = state;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    in_bus      = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    expire      = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RD_ID;
      RD_ID: begin
        in_bus   = 1'b1;
        avm_read = 1'b1;
        if (!avm_waitrequest) state_nx = WT_ID;
      end
      WT_ID: begin
        in_bus = 1'b1;
        if (avm_readdatavalid) begin
          cap_id   = 1'b1;
          state_nx = RD_TS;
        end
      end
      RD_TS: begin
        in_bus      = 1'b1;
        avm_read    = 1'b1;
        avm_address = 1'b1;
        if (!avm_waitrequest) state_nx = WT_TS;
      end
      WT_TS: begin
        in_bus = 1'b1;
        if (avm_readdatavalid) begin
          cap_ts   = 1'b1;
          state_nx = FIN;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // A bus state that has made no progress by its last allowed cycle is abandoned.
    if (in_bus && (state_nx == state) && ((cnt + 16'd1) >= TIMEOUT_CYCLES)) begin
      expire   = 1'b1;
      state_nx = FIN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      done     <= 1'b0;
      pass     <= 1'b0;
      id_err   <= 1'b0;
      ts_err   <= 1'b0;
      timeout  <= 1'b0;
      id_value <= 32'd0;
      ts_value <= 32'd0;
    end else begin
      state <= state_nx;
      done  <= (state == FIN);
      if (state_nx != state || !in_bus) cnt <= 16'd0;
      else                              cnt <= cnt + 16'd1;

      if (state == IDLE && start) begin
        pass     <= 1'b0;
        id_err   <= 1'b0;
        ts_err   <= 1'b0;
        timeout  <= 1'b0;
        id_value <= 32'd0;
        ts_value <= 32'd0;
      end
      if (cap_id) begin
        id_value <= avm_readdata;
        id_err   <= (avm_readdata != EXPECTED_ID);
      end
      if (cap_ts) begin
        ts_value <= avm_readdata;
        ts_err   <= (avm_readdata != EXPECTED_TS);
      end
      if (expire) timeout <= 1'b1;
      if (state == FIN) pass <= ~id_err & ~ts_err & ~timeout;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sysid_probe.sv
// Scoreboard bench for sysid_probe: a randomized Avalon slave feeds the probe,
// expected results are queued at start and checked when done pulses.
module tb_sysid_probe;
  import sysid_pkg::*;

  localparam logic [15:0] TMO    = 16'd8;
  localparam logic [31:0] EXP_ID = DEFAULT_ID;
  localparam logic [31:0] EXP_TS = DEFAULT_TS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, pass, id_err, ts_err, timeout;
  logic [31:0] id_value, ts_value;

  typedef struct {
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        id_err;
    logic        ts_err;
    logic        timeout;
    logic        pass;
    logic        ts_read;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          ws_id, lat_id, ws_ts, lat_ts;
  logic [31:0] d_id, d_ts;
  logic        no_rdv = 1'b0;

  sysid_probe #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy),
    .done(done),
    .pass(pass),
    .id_err(id_err),
    .ts_err(ts_err),
    .timeout(timeout),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
    checkOutput({tag, "_id_err"}, 32'(id_err), 32'd0);
    checkOutput({tag, "_ts_err"}, 32'(ts_err), 32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout), 32'd0);
    checkOutput({tag, "_id_value"}, id_value, 32'd0);
    checkOutput({tag, "_ts_value"}, ts_value, 32'd0);
    checkOutput({tag, "_read"}, 32'(avm_read), 32'd0);
    checkOutput({tag, "_address"}, 32'(avm_address), 32'd0);
  endtask

  // Slave: stall for ws cycles, then return data lat cycles after acceptance.
  initial begin : slave
    logic addr;
    int   ws, lat;
    forever begin
      if (!avm_read || !reset_n) begin
        @(negedge clk);
      end else begin
        addr = avm_address;
        ws   = addr ? ws_ts : ws_id;
        lat  = addr ? lat_ts : lat_id;
        for (int i = 0; i < ws; i++) begin
          avm_waitrequest = 1'b1;
          @(negedge clk);
          checkOutput("stall_read", 32'(avm_read), 32'd1);
          checkOutput("stall_addr", 32'(avm_address), 32'(addr));
        end
        avm_waitrequest = 1'b0;
        if (!addr && no_rdv) begin
          @(negedge clk);
        end else begin
          repeat (lat) @(negedge clk);
          avm_readdatavalid = 1'b1;
          avm_readdata      = addr ? d_ts : d_id;
          @(negedge clk);
          avm_readdatavalid = 1'b0;
          avm_readdata      = $urandom;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever done pulses.
  initial begin : monitor
    logic ts_seen;
    exp_t e;
    ts_seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) ts_seen = 1'b0;
      else if (avm_read && avm_address) ts_seen = 1'b1;
      if (!avm_read) checkOutput("idle_address", 32'(avm_address), 32'd0);
      if (done && reset_n) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_cycle", cyc, e.done_cyc);
          checkOutput("pass", 32'(pass), 32'(e.pass));
          checkOutput("id_err", 32'(id_err), 32'(e.id_err));
          checkOutput("ts_err", 32'(ts_err), 32'(e.ts_err));
          checkOutput("timeout", 32'(timeout), 32'(e.timeout));
          checkOutput("id_value", id_value, e.id_value);
          checkOutput("ts_value", ts_value, e.ts_value);
          checkOutput("ts_read_issued", 32'(ts_seen), 32'(e.ts_read));
          checkOutput("busy_at_done", 32'(busy), 32'd0);
          ts_seen = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input int wi, input int li, input logic [31:0] di,
                               input int wt, input int lt, input logic [31:0] dt,
                               input logic nr, input logic push);
    exp_t e;
    ws_id  = wi;
    lat_id = li;
    d_id   = di;
    ws_ts  = wt;
    lat_ts = lt;
    d_ts   = dt;
    no_rdv = nr;
    e.timeout  = nr;
    e.ts_read  = !nr;
    e.id_value = nr ? 32'd0 : di;
    e.ts_value = nr ? 32'd0 : dt;
    e.id_err   = !nr && (di != EXP_ID);
    e.ts_err   = !nr && (dt != EXP_TS);
    e.pass     = !nr && (di == EXP_ID) && (dt == EXP_TS);
    @(negedge clk);
    if (nr) e.done_cyc = cyc + 1 + (wi + 1) + int'(TMO) + 1;
    else    e.done_cyc = cyc + 1 + (wi + 1) + li + (wt + 1) + lt + 1;
    if (push) sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int   n;
    logic found;
    repeat (2) @(negedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal: zero wait states, latency 1.
    applyStimulus(0, 1, EXP_ID, 0, 1, EXP_TS, 1'b0, 1'b1);
    waitDone(50);
    checkOutput("pass_hold", 32'(pass), 32'd1);

    // Wrong ID word, timestamp still read.
    applyStimulus(0, 1, 32'd0, 0, 1, EXP_TS, 1'b0, 1'b1);
    waitDone(50);

    // Stalls of 3 cycles and latency 2.
    applyStimulus(3, 2, EXP_ID, 3, 2, EXP_TS, 1'b0, 1'b1);
    waitDone(50);

    // ID read never returns data.
    applyStimulus(0, 1, $urandom, 0, 1, EXP_TS, 1'b1, 1'b1);
    waitDone(50);

    // Reset during the timestamp wait, stray readdatavalid afterwards.
    applyStimulus(0, 1, EXP_ID, 0, 4, EXP_TS, 1'b0, 1'b0);
    n = 0;
    found = 1'b0;
    while (!found && n < 50) begin
      @(negedge clk);
      #1;
      if (avm_read && avm_address && !avm_waitrequest) found = 1'b1;
      n++;
    end
    checkOutput("ts_read_reached", 32'(found), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checkResetValues("stray_rdv");
    applyStimulus(1, 2, EXP_ID, 0, 1, EXP_TS, 1'b0, 1'b1);
    waitDone(50);

    // Second start while busy must be ignored.
    applyStimulus(1, 1, EXP_ID, 1, 1, EXP_TS, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(50);
    repeat (10) @(negedge clk);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      applyStimulus($urandom_range(0, 4), $urandom_range(1, 4),
                    ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom,
                    $urandom_range(0, 4), $urandom_range(1, 4),
                    ($urandom_range(0, 1) != 0) ? EXP_TS : $urandom,
                    1'b0, 1'b1);
      waitDone(60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
